uart_tx: RTL and testbench

UART transmitter for the system project. It sits at the TX end of the link, opposite the UART receiver and its parity checker. It accepts a parallel byte with a valid strobe and serialises it as a frame: start bit, data LSB first, optional parity, stop bit. One bit goes out per `clk_TX` cycle, because `clk_TX` is already the divided baud clock. Parity convention matches the receiver: `PAR_TYP`=1 selects even, `PAR_TYP`=0 selects odd.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_serializer.sv | 46 ++++
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, default width, line levels and the
// PAR_TYP even/odd convention used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    localparam logic PAR_EVEN = 1'b1;
    localparam logic PAR_ODD  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Even parity makes the total count of ones even, so the bit equals the
    // reduction XOR of the payload; odd parity is its complement.
    function automatic logic parity_bit(input logic red_xor, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~red_xor : red_xor;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register and bit counter for the UART transmitter data phase.
// o_bit is the next bit to put on the line; o_done marks the last data bit.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk_TX,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic                  i_cnt_clr,
    input  logic                  i_cnt_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_bit,
    output logic                  o_done
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;

    always_ff @(posedge clk_TX or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            if (i_load) begin
                r_shift <= i_data;
            end else if (i_shift) begin
                r_shift <= r_shift >> 1;
            end

            if (i_load || i_cnt_clr) begin
                r_cnt <= '0;
            end else if (i_cnt_en) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_bit  = r_shift[0];
    assign o_done = (r_cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, optional parity, stop.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk_TX,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic [2:0]            o_dbg_state
);

    tx_state_e r_state;
    tx_state_e w_next_state;
    logic      r_tx;
    logic      r_busy;
    logic      w_tx_next;
    logic      w_busy_next;
    logic      w_accept;
    logic      w_shift;
    logic      w_cnt_clr;
    logic      w_cnt_en;
    logic      w_bit;
    logic      w_done;
    logic      w_par_en;
    logic      w_par_bit;

    assign w_accept = (r_state == ST_IDLE) && Data_Valid;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk_TX    (clk_TX),
        .rst       (rst),
        .i_load    (w_accept),
        .i_shift   (w_shift),
        .i_cnt_clr (w_cnt_clr),
        .i_cnt_en  (w_cnt_en),
        .i_data    (P_DATA),
        .o_bit     (w_bit),
        .o_done    (w_done)
    );

`ifdef UART_TX_PARITY_EN
    logic r_par_en;
    logic r_par_bit;

    // Parity of the accepted byte is fixed at accept, so later P_DATA or
    // PAR_TYP changes cannot disturb the frame in flight.
    always_ff @(posedge clk_TX or negedge rst) begin
        if (!rst) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_par_en  <= PAR_EN;
            r_par_bit <= parity_bit(^P_DATA, PAR_TYP);
        end
    end

    assign w_par_en  = r_par_en;
    assign w_par_bit = r_par_bit;
`else
    logic w_unused_par;
    assign w_unused_par = &{1'b0, PAR_EN, PAR_TYP};
    assign w_par_en     = 1'b0;
    assign w_par_bit    = LINE_STOP;
`endif

    // Outputs are computed for the state being entered, so each state's line
    // level is visible during the same cycle the state is occupied.
    always_comb begin
        w_next_state = r_state;
        w_tx_next    = LINE_IDLE;
        w_busy_next  = 1'b1;
        w_shift      = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy_next = 1'b0;
                if (Data_Valid) begin
                    w_next_state = ST_START;
                    w_tx_next    = LINE_START;
                    w_busy_next  = 1'b1;
                end
            end
            ST_START: begin
                w_next_state = ST_DATA;
                w_tx_next    = w_bit;
                w_shift      = 1'b1;
                w_cnt_clr    = 1'b1;
            end
            ST_DATA: begin
                if (w_done) begin
                    if (w_par_en) begin
                        w_next_state = ST_PARITY;
                        w_tx_next    = w_par_bit;
                    end else begin
                        w_next_state = ST_STOP;
                        w_tx_next    = LINE_STOP;
                    end
                end else begin
                    w_tx_next = w_bit;
                    w_shift   = 1'b1;
                    w_cnt_en  = 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                w_next_state = ST_STOP;
                w_tx_next    = LINE_STOP;
            end
`endif
            ST_STOP: begin
                w_next_state = ST_IDLE;
                w_tx_next    = LINE_IDLE;
                w_busy_next  = 1'b0;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_TX or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_tx    <= LINE_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
        end
    end

    assign TX_OUT      = r_tx;
    assign Busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus randomized frames
// checked cycle by cycle against a frame model built from the protocol rules.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic          clk_TX = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          TX_OUT;
    logic          Busy;
    logic [2:0]    dbg_state;

    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_q[$];

    uart_tx #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk_TX      (clk_TX),
        .rst         (rst),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .TX_OUT      (TX_OUT),
        .Busy        (Busy),
        .o_dbg_state (dbg_state)
    );

    always #5 clk_TX = ~clk_TX;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line sequence for one frame, straight from the framing rules.
    function automatic void build_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp);
        int  ones;
        bit  with_par;
        ones     = $countones(d);
        with_par = pen && PAR_BUILT;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        if (with_par) begin
            if (ptyp == PAR_EVEN) exp_q.push_back(1'((ones % 2) == 1));
            else                  exp_q.push_back(1'((ones % 2) == 0));
        end
        exp_q.push_back(1'b1);
    endfunction

    // Called at a negedge with the DUT idle. Returns at the negedge of the
    // idle cycle after the stop bit. With hold set, Data_Valid stays high.
    task automatic run_frame(input string tag, input logic [DW-1:0] d, input logic pen,
                             input logic ptyp, input bit hold);
        logic b;
        int   k;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        Data_Valid = 1'b1;
        build_frame(d, pen, ptyp);
        @(posedge clk_TX);
        @(negedge clk_TX);
        if (!hold) Data_Valid = 1'b0;
        k = 0;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check($sformatf("%s tx[%0d]", tag, k), 32'(TX_OUT), 32'(b));
            check($sformatf("%s busy[%0d]", tag, k), 32'(Busy), 32'd1);
            P_DATA  = DW'($urandom);
            PAR_EN  = 1'($urandom_range(0, 1));
            PAR_TYP = 1'($urandom_range(0, 1));
            k++;
            @(negedge clk_TX);
        end
        check($sformatf("%s idle_tx", tag), 32'(TX_OUT), 32'd1);
        check($sformatf("%s idle_busy", tag), 32'(Busy), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] d;
        bit            hold;
        bit            prev_hold;

        rst = 1'b0;
        repeat (3) @(negedge clk_TX);
        check("reset tx", 32'(TX_OUT), 32'd1);
        check("reset busy", 32'(Busy), 32'd0);
        rst = 1'b1;
        @(negedge clk_TX);
        check("post_reset tx", 32'(TX_OUT), 32'd1);
        check("post_reset busy", 32'(Busy), 32'd0);

        run_frame("a5_even", 8'hA5, 1'b1, PAR_EVEN, 1'b0);
        run_frame("a5_odd",  8'hA5, 1'b1, PAR_ODD,  1'b0);
        run_frame("00_odd",  8'h00, 1'b1, PAR_ODD,  1'b0);
        run_frame("ff_even", 8'hFF, 1'b1, PAR_EVEN, 1'b0);
        run_frame("3c_nopar", 8'h3C, 1'b0, PAR_EVEN, 1'b0);
        repeat (2) @(negedge clk_TX);

        run_frame("b2b_0", 8'h5A, 1'b1, PAR_EVEN, 1'b1);
        run_frame("b2b_1", 8'hC3, 1'b0, PAR_ODD,  1'b1);
        run_frame("b2b_2", 8'h81, 1'b1, PAR_ODD,  1'b0);

        // Reset during data bit 4 (0x69 has bit 4 low so the forced 1 shows).
        P_DATA     = 8'h69;
        PAR_EN     = 1'b1;
        PAR_TYP    = PAR_EVEN;
        Data_Valid = 1'b1;
        @(posedge clk_TX);
        @(negedge clk_TX);
        Data_Valid = 1'b0;
        check("rst_mid start", 32'(TX_OUT), 32'd0);
        repeat (5) @(negedge clk_TX);
        check("rst_mid bit4", 32'(TX_OUT), 32'd0);
        check("rst_mid busy", 32'(Busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid async tx", 32'(TX_OUT), 32'd1);
        check("rst_mid async busy", 32'(Busy), 32'd0);
        @(negedge clk_TX);
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_TX);
            check($sformatf("rst_idle tx[%0d]", i), 32'(TX_OUT), 32'd1);
            check($sformatf("rst_idle busy[%0d]", i), 32'(Busy), 32'd0);
        end

        // Data_Valid presented in the cycle reset releases.
        rst = 1'b0;
        @(negedge clk_TX);
        rst = 1'b1;
        run_frame("rel_accept", 8'h96, 1'b1, PAR_ODD, 1'b0);

        prev_hold = 1'b0;
        for (int n = 0; n < 24; n++) begin
            if (!prev_hold) repeat ($urandom_range(0, 3)) @(negedge clk_TX);
            d    = DW'($urandom);
            hold = 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", n), d, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), hold);
            prev_hold = hold;
        end
        Data_Valid = 1'b0;
        repeat (3) @(negedge clk_TX);
        check("final tx", 32'(TX_OUT), 32'd1);
        check("final busy", 32'(Busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
